nios2os_pio_key: RTL

//  Avalon-MM slave input PIO: samples WIDTH board keys, debounces each bit, latches selected edges

---
 rtl/nios2os_pio_pkg.sv | 22 ++
 rtl/nios2os_pio_debounce.sv | 57 +++++
 rtl/nios2os_pio_key.sv | 91 +++++++++
 3 files changed

// File: rtl/nios2os_pio_pkg.sv
// Shared constants for the Nios II input PIO: Avalon register offsets,
// edge-select encodings and the default debounce interval.
package nios2os_pio_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_DIR     = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE    = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   // 20 ms at 50 MHz
   localparam int DEBOUNCE_CYC_DEF = 1000000;

   // A bypassed debouncer still needs a legal (non-zero) counter width.
   function automatic int cnt_width(input int cyc);
      return (cyc < 1) ? 1 : $clog2(cyc + 1);
   endfunction

endpackage

// File: rtl/nios2os_pio_debounce.sv
// One key bit: 2-FF synchronizer followed by a hold-time debouncer.
// The output only follows the input after it has differed for DEBOUNCE_CYC cycles.
module nios2os_pio_debounce
   import nios2os_pio_pkg::*;
#(
   parameter int   DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
   parameter logic RESET_LEVEL  = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_key,
   output logic o_key
);

   logic r_s1;
   logic r_s2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1 <= RESET_LEVEL;
         r_s2 <= RESET_LEVEL;
      end else begin
         r_s1 <= i_key;
         r_s2 <= r_s1;
      end
   end

   generate
      if (DEBOUNCE_CYC == 0) begin : g_bypass
         assign o_key = r_s2;
      end else begin : g_count
         localparam int CW = cnt_width(DEBOUNCE_CYC);
         localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

         logic [CW-1:0] r_cnt;
         logic          r_deb;

         // Any return to the accepted level restarts the hold interval.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_cnt <= '0;
               r_deb <= RESET_LEVEL;
            end else if (r_s2 == r_deb) begin
               r_cnt <= '0;
            end else if (r_cnt == LAST) begin
               r_deb <= r_s2;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         assign o_key = r_deb;
      end
   endgenerate

endmodule

// File: rtl/nios2os_pio_key.sv
// Avalon-MM input PIO for board keys: debounced data, sticky edge capture,
// maskable level irq. Zero-wait writes, reads registered (one wait state).
module nios2os_pio_key
   import nios2os_pio_pkg::*;
#(
   parameter int   WIDTH        = 4,
   parameter int   DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
   parameter int   EDGE_TYPE    = EDGE_FALL,
   parameter logic RESET_LEVEL  = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] w_deb;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] w_clr;
   logic             w_wr;
   logic             w_unused;
   logic [31:0]      w_rd_mux;

   logic [WIDTH-1:0] r_deb_d;
   logic [WIDTH-1:0] r_edge_cap;
   logic [WIDTH-1:0] r_irq_mask;
   logic [31:0]      r_readdata;
   logic             r_irq;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      nios2os_pio_debounce #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .RESET_LEVEL  (RESET_LEVEL)
      ) u_debounce (
         .clk     (clk),
         .reset_n (reset_n),
         .i_key   (in_port[gi]),
         .o_key   (w_deb[gi])
      );
   end

   always_comb begin
      w_edge = '0;
      case (EDGE_TYPE)
         EDGE_RISE: w_edge = w_deb & ~r_deb_d;
         EDGE_FALL: w_edge = ~w_deb & r_deb_d;
         default:   w_edge = w_deb ^ r_deb_d;
      endcase
   end

   assign w_wr     = chipselect & ~write_n;
   assign w_clr    = (w_wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
   assign w_unused = ^writedata;

   always_comb begin
      w_rd_mux = '0;
      case (address)
         ADDR_DATA:    w_rd_mux[WIDTH-1:0] = w_deb;
         ADDR_IRQMASK: w_rd_mux[WIDTH-1:0] = r_irq_mask;
         ADDR_EDGE:    w_rd_mux[WIDTH-1:0] = r_edge_cap;
         default:      w_rd_mux = '0;
      endcase
   end

   // A new edge wins over a clear landing in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_deb_d    <= {WIDTH{RESET_LEVEL}};
         r_edge_cap <= '0;
         r_irq_mask <= '0;
         r_readdata <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_deb_d    <= w_deb;
         r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
         r_readdata <= w_rd_mux;
         r_irq      <= |(r_edge_cap & r_irq_mask);
         if (w_wr && address == ADDR_IRQMASK)
            r_irq_mask <= writedata[WIDTH-1:0];
      end
   end

   assign readdata = r_readdata;
   assign irq      = r_irq;

endmodule
